// File: rtl/rvsv_pkg.sv
// Shared definitions for the program loader.
//   loader_state_t : loader FSM state encoding
//   LEN_BYTES      : number of bytes in the little-endian length header
package rvsv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

  localparam int LEN_BYTES = 4;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// byte_assembler: collects W/8 bytes into a W-bit little-endian word.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clr          : restart assembly (count and word cleared)
//   push         : accept in_byte this cycle
//   in_byte      : incoming byte
//   word         : shift register; after W/8 pushes the first byte sits in [7:0]
//   full         : this push completes a word (count wraps to zero on the same edge)
module byte_assembler #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic [7:0]   in_byte,
  output logic [W-1:0] word,
  output logic         full
);

  localparam int N  = W / 8;
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  assign full = push && (cnt == CW'(N - 1));

  // New bytes enter at the top so the first byte ends up in the lowest lane.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (push) begin
      word <= (word >> 8) | (W'(in_byte) << (W - 8));
      cnt  <= full ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: write side of the instruction memory. Consumes the byte stream
// {LEN[31:0], word0, word1, ...} (little-endian) and writes LEN words to
// consecutive byte addresses starting at base_addr.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   start, base_addr     : begin a load at base_addr (accepted only in IDLE/DONE)
//   in_byte, in_valid    : byte stream input
//   in_ready             : stream byte accepted when in_valid & in_ready
//   pc, wdata, write_en  : inst_mem write port; pc/wdata qualified by write_en
//   busy, done           : load in progress / load complete (held until next start)
//   word_count           : words written in the current load
module inst_loader
  import rvsv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [ILEN-1:0] base_addr,
  input  logic [7:0]      in_byte,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [ILEN-1:0] pc,
  output logic [ILEN-1:0] wdata,
  output logic            write_en,
  output logic            busy,
  output logic            done,
  output logic [31:0]     word_count
);

  localparam int BPW = ILEN / 8;

  if ((ILEN % 8) != 0 || ILEN < 8 || XLEN < 1) begin : g_bad_param
    $error("inst_loader: ILEN must be a positive multiple of 8");
  end

  loader_state_t state, state_nxt;

  logic        start_acc;
  logic        transfer;
  logic        len_push, len_full;
  logic        dat_push, dat_full;
  logic [31:0] len_word, len_value;
  logic [ILEN-1:0] dat_word;

  assign transfer  = in_valid && in_ready;
  assign start_acc = start && (state == IDLE || state == DONE);
  assign len_push  = transfer && (state == LEN);
  assign dat_push  = transfer && (state == DATA);

  // Length as it will read once the byte being accepted now is included;
  // lets LEN==0 go straight to DONE on the 4th byte's edge.
  assign len_value = (len_word >> 8) | (32'(in_byte) << 24);

  byte_assembler #(.W(8 * LEN_BYTES)) u_len_asm (
    .clock  (clock),
    .reset  (reset),
    .clr    (start_acc),
    .push   (len_push),
    .in_byte(in_byte),
    .word   (len_word),
    .full   (len_full)
  );

  byte_assembler #(.W(ILEN)) u_dat_asm (
    .clock  (clock),
    .reset  (reset),
    .clr    (start_acc),
    .push   (dat_push),
    .in_byte(in_byte),
    .word   (dat_word),
    .full   (dat_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // len_word holds the full length once LEN is left; no further pushes reach it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LEN;
      LEN:        if (len_full) state_nxt = (len_value == 32'd0) ? DONE : DATA;
      DATA:       if (dat_full) state_nxt = WRITE;
      WRITE:      state_nxt = (word_count + 32'd1 == len_word) ? DONE : DATA;
      default:    state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == LEN) || (state == DATA);
  assign write_en = (state == WRITE);
  assign busy     = (state == LEN) || (state == DATA) || (state == WRITE);
  assign done     = (state == DONE);

  // wdata is captured whole on the last byte so it stays stable between writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      wdata      <= '0;
      word_count <= '0;
    end else begin
      if (start_acc) begin
        pc         <= base_addr;
        word_count <= '0;
      end else if (state == WRITE) begin
        pc         <= pc + ILEN'(BPW);
        word_count <= word_count + 32'd1;
      end
      if (dat_full) wdata <= (dat_word >> 8) | (ILEN'(in_byte) << (ILEN - 8));
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] wdata;
  logic        write_en;
  logic        busy;
  logic        done;
  logic [31:0] word_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_xfer_cyc = 0;

  logic [31:0] words_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          lastb_q[$];

  inst_loader #(.XLEN(32), .ILEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc        (pc),
    .wdata     (wdata),
    .write_en  (write_en),
    .busy      (busy),
    .done      (done),
    .word_count(word_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record every write strobe; the loader must not take bytes while writing.
  always @(negedge clock) begin
    if (write_en === 1'b1) begin
      wr_addr_q.push_back(pc);
      wr_data_q.push_back(wdata);
      wr_cyc_q.push_back(cyc);
      chk("rdy_in_write", 32'(in_ready), 32'd0);
    end
  end

  // gap_mode: 0 = back-to-back, 1 = one idle cycle before each byte, 2 = random idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int n;
    int waited;
    n = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    in_byte  = b;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clock);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited > 40) begin
        chk("ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clock);
    #1;
    last_xfer_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic begin_load(input logic [31:0] base);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    lastb_q.delete();
    start     = 1'b1;
    base_addr = base;
    @(posedge clock);
    #1;
    start     = 1'b0;
    base_addr = $urandom;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_pc", pc, base);
    chk("start_cnt", word_count, 32'd0);
  endtask

  // Full load of words_q; expectations come from the word list and base address alone.
  task automatic run_load(input logic [31:0] base, input int gap_mode, input bit poke_start);
    logic [31:0] len;
    logic [31:0] w;
    int n;
    n   = words_q.size();
    len = 32'(n);
    begin_load(base);
    for (int k = 0; k < 4; k++) begin
      send_byte(len[8*k +: 8], gap_mode);
      if (poke_start && k == 1) begin
        start     = 1'b1;
        base_addr = 32'hDEAD0000;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("busy_start_pc", pc, base);
        chk("busy_start_busy", 32'(busy), 32'd1);
      end
    end
    if (n == 0) begin
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_mode);
      lastb_q.push_back(last_xfer_cyc);
    end
    for (int t = 0; t < 20 && done !== 1'b1; t++) @(negedge clock);
    chk("end_done", 32'(done), 32'd1);
    chk("n_writes", 32'(wr_addr_q.size()), len);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], base + 32'(4 * i));
      chk($sformatf("wr_data[%0d]", i), wr_data_q[i], words_q[i]);
      chk($sformatf("wr_lat[%0d]", i), 32'(wr_cyc_q[i]), 32'(lastb_q[i]));
    end
    chk("end_cnt", word_count, len);
    chk("end_pc", pc, base + 32'(4 * n));
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_byte   = '0;
    in_valid  = 1'b0;
    #22;
    chk("rst_pc", pc, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_cnt", word_count, 32'd0);
    chk("rst_flags", {28'd0, in_ready, write_en, busy, done}, 32'd0);
    reset = 1'b0;
    #1;

    // Bytes offered while idle must be refused.
    in_byte  = 8'h55;
    in_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clock);
    #1;

    // Single word at address zero.
    words_q = '{32'h00500013};
    run_load(32'h0, 0, 1'b0);

    repeat (3) @(negedge clock);
    chk("done_held", 32'(done), 32'd1);
    @(posedge clock);
    #1;

    // Three words, with a start pulse during the header that must be ignored.
    words_q = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
    run_load(32'h100, 0, 1'b1);

    // Empty program.
    words_q.delete();
    run_load(32'h400, 0, 1'b0);

    // in_valid toggling every other cycle.
    words_q = '{32'h12345678, 32'h9ABCDEF0};
    run_load(32'h800, 1, 1'b0);

    // Address wrap past the top of the space.
    words_q = '{32'h11111111, 32'h22222222};
    run_load(32'hFFFFFFFC, 0, 1'b0);

    // Reset in the middle of word1: state and outputs clear without a clock edge.
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    begin_load(32'h200);
    for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'd3 : 8'd0, 0);
    for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k), 0);
    send_byte(8'hB0, 0);
    send_byte(8'hB1, 0);
    repeat (2) @(negedge clock);
    chk("pre_rst_writes", 32'(wr_addr_q.size()), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_wdata", wdata, 32'd0);
    chk("mid_rst_cnt", word_count, 32'd0);
    chk("mid_rst_flags", {28'd0, in_ready, write_en, busy, done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    words_q = '{32'hCAFEF00D};
    run_load(32'h300, 0, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] rb;
      int rn;
      rb = $urandom & 32'hFFFFFFFC;
      rn = int'($urandom_range(1, 4));
      words_q.delete();
      for (int i = 0; i < rn; i++) words_q.push_back($urandom);
      run_load(rb, (r % 2 == 0) ? 0 : 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
